// File: rtl/button_event_pkg.sv
// Shared register map and event-entry layout for the push-button event controller.
package button_event_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE  = 2'd2;
  localparam logic [1:0] ADDR_EVENT = 2'd3;

  localparam int EVT_ID_W     = 3;
  localparam int OVF_BIT      = 8;
  localparam int NONEMPTY_BIT = 31;
  localparam int COUNT_LSB    = 16;
  localparam int TYPE_BIT     = 4;

  typedef struct packed {
    logic                press;
    logic [EVT_ID_W-1:0] id;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  // Head fields stay zero when empty so software never sees a stale entry.
  function automatic logic [31:0] make_event_word(input logic       non_empty,
                                                  input logic [2:0] count_sat,
                                                  input logic       ovf,
                                                  input evt_t       head);
    logic [31:0] w;
    w = '0;
    w[NONEMPTY_BIT]             = non_empty;
    w[COUNT_LSB+2:COUNT_LSB]    = count_sat;
    w[OVF_BIT]                  = ovf;
    if (non_empty) begin
      w[TYPE_BIT]               = head.press;
      w[EVT_ID_W-1:0]           = head.id;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_debounce_bit.sv
// One button: 2-FF synchroniser, tick-sampled stability counter and debounced level.
module button_debounce_bit
  import button_event_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic tick,
  output logic level,
  output logic flip
);

  localparam int   CNT_W        = $clog2(STABLE_TICKS + 1);
  localparam logic RELEASED_PIN = ACTIVE_LOW;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pressed_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RELEASED_PIN;
      sync2_q <= RELEASED_PIN;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    level_d     = level_q;
    flip        = 1'b0;
    pressed_raw = ACTIVE_LOW ? ~sync2_q : sync2_q;
    if (tick) begin
      if (pressed_raw != level_q) begin
        // The tick that completes the run flips the level rather than storing STABLE_TICKS.
        if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
          level_d = ~level_q;
          cnt_d   = '0;
          flip    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_event_controller.sv
// Avalon-MM push-button controller: debounce, W1C edge capture with maskable irq,
// and a press/release event FIFO fed by a lowest-index-first arbiter.
module button_event_controller
  import button_event_pkg::*;
#(
  parameter int WIDTH        = 7,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int CLK_DIV      = 50000,
  parameter int STABLE_TICKS = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] level, flip;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  evt_t             fifo_q [FIFO_DEPTH];
  evt_t             fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      readdata_q, readdata_d;

  logic                grant_vld, grant_press;
  logic [EVT_ID_W-1:0] grant_idx;
  logic [WIDTH-1:0]    grant_onehot;
  logic                non_empty, full, pop, push, drop;
  logic                wr_mask, wr_edge, wr_event;
  logic [31:0]         count_ext;
  logic [2:0]          count_sat;
  evt_t                head;
  logic                unused_wd;

  assign tick = (presc_q == PRE_W'(CLK_DIV - 1));

  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
    button_debounce_bit #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_db (
      .clk   (clk),
      .rst   (reset),
      .pin   (in_port[i]),
      .tick  (tick),
      .level (level[i]),
      .flip  (flip[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      pending_q  <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      readdata_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      presc_q    <= presc_d;
      pending_q  <= pending_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PRE_W'(1);

    // Descending scan so the lowest set index is the one left standing.
    grant_vld    = 1'b0;
    grant_press  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_vld       = 1'b1;
        grant_press     = level[i];
        grant_idx       = EVT_ID_W'(i);
        grant_onehot    = '0;
        grant_onehot[i] = 1'b1;
      end
    end

    non_empty = (count_q != '0);
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = chipselect & read & (address == ADDR_EVENT) & non_empty;
    push      = grant_vld & (~full | pop);
    drop      = grant_vld & full & ~pop;

    wr_mask   = chipselect & write & (address == ADDR_MASK);
    wr_edge   = chipselect & write & (address == ADDR_EDGE);
    wr_event  = chipselect & write & (address == ADDR_EVENT);

    for (int i = 0; i < FIFO_DEPTH; i++) fifo_d[i] = fifo_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{press: grant_press, id: grant_idx};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    pending_d = (pending_q & ~grant_onehot) | flip;
    edge_d    = (edge_q & ~(wr_edge ? writedata[WIDTH-1:0] : '0)) | (flip & ~level);
    mask_d    = wr_mask ? writedata[WIDTH-1:0] : mask_q;
    ovf_d     = drop | (ovf_q & ~(wr_event & writedata[OVF_BIT]));

    count_ext = 32'(count_q);
    count_sat = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
    head      = fifo_q[rd_ptr_q];

    case (address)
      ADDR_DATA:  readdata_d = 32'(level);
      ADDR_MASK:  readdata_d = 32'(mask_q);
      ADDR_EDGE:  readdata_d = 32'(edge_q);
      default:    readdata_d = make_event_word(non_empty, count_sat, ovf_q, head);
    endcase
  end

  assign readdata  = readdata_q;
  assign irq       = |(edge_q & mask_q);
  assign unused_wd = ^writedata;

endmodule
